image_rom_arbiter: RTL and testbench

//  Shares one bank of synchronous-read 96x64 RGB565 image ROMs (one ROM per level, 1-cycle read latency)

---
 rtl/image_rom_arbiter_if.sv | 29 ++
 rtl/image_rom_arbiter.sv | 153 +++++++++++++++
 tb/tb_image_rom_arbiter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/image_rom_arbiter_if.sv
// Requester-side handshake bundle for the image ROM arbiter: display and physics ports.
interface image_rom_arbiter_if #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 16
);
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_gnt;
  logic              disp_valid;
  logic [DATA_W-1:0] disp_data;

  logic              phys_req;
  logic [ADDR_W-1:0] phys_addr;
  logic              phys_gnt;
  logic              phys_valid;
  logic [DATA_W-1:0] phys_data;

  // Requesters drive req/addr and consume grants and responses.
  modport master (
    output disp_req, disp_addr, phys_req, phys_addr,
    input  disp_gnt, disp_valid, disp_data, phys_gnt, phys_valid, phys_data
  );

  // The arbiter consumes requests and produces grants and responses.
  modport slave (
    input  disp_req, disp_addr, phys_req, phys_addr,
    output disp_gnt, disp_valid, disp_data, phys_gnt, phys_valid, phys_data
  );
endinterface

// File: rtl/image_rom_arbiter.sv
// Shares one bank of synchronous-read level ROMs between the display fetcher (high priority)
// and physics lookup, with a starvation guard for physics and frame-aligned level switching.
module image_rom_arbiter #(
  parameter int unsigned NUM_ROMS = 4,
  parameter int unsigned LVL_W    = 2,
  parameter int unsigned ADDR_W   = 13,
  parameter int unsigned PIXELS   = 6144,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       frame_start,
  input  logic [LVL_W-1:0]           level_req,
  output logic [LVL_W-1:0]           level_cur,
  image_rom_arbiter_if.slave         bus,
  output logic [ADDR_W-1:0]          rom_addr,
  input  logic [NUM_ROMS*DATA_W-1:0] rom_data_all
);

  localparam int unsigned WAIT_W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

  localparam logic IdDisp = 1'b0;
  localparam logic IdPhys = 1'b1;

  logic              starve;
  logic              disp_gnt;
  logic              phys_gnt;
  logic              any_gnt;
  logic [ADDR_W-1:0] gnt_addr;
  logic              gnt_oor;

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [LVL_W-1:0]  level_q;
  logic [ADDR_W-1:0] rom_addr_q;

  // Stage 1: address issued to ROMs; stage 2: ROM data now registered inside the ROMs.
  logic              s1_vld_q, s1_id_q, s1_oor_q;
  logic [LVL_W-1:0]  s1_lvl_q;
  logic              s2_vld_q, s2_id_q, s2_oor_q;
  logic [LVL_W-1:0]  s2_lvl_q;

  logic [DATA_W-1:0] rom_word;

  logic              disp_valid_q, phys_valid_q;
  logic [DATA_W-1:0] disp_data_q, phys_data_q;

  // Fixed priority to display unless physics has waited WAIT_MAX cycles.
  always_comb begin
    starve   = bus.phys_req && (wait_q == WAIT_W'(WAIT_MAX));
    phys_gnt = bus.phys_req && (starve || !bus.disp_req);
    disp_gnt = bus.disp_req && !starve;
    any_gnt  = disp_gnt || phys_gnt;
    gnt_addr = phys_gnt ? bus.phys_addr : bus.disp_addr;
    gnt_oor  = 32'(gnt_addr) >= PIXELS;
  end

  // Physics wait counter: cleared when served or idle, saturating otherwise.
  always_comb begin
    wait_d = wait_q;
    if (!bus.phys_req || phys_gnt) begin
      wait_d = '0;
    end else if (wait_q != WAIT_W'(WAIT_MAX)) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  // Select the word of the ROM belonging to the level the read was issued under.
  always_comb begin
    rom_word = '0;
    for (int unsigned k = 0; k < NUM_ROMS; k++) begin
      if (s2_lvl_q == LVL_W'(k)) begin
        rom_word = rom_data_all[k*DATA_W +: DATA_W];
      end
    end
  end

  // Level and wait-counter state; new levels only latch on frame start and only if a ROM exists.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= '0;
      wait_q  <= '0;
    end else begin
      wait_q <= wait_d;
      if (frame_start && (32'(level_req) < NUM_ROMS)) begin
        level_q <= level_req;
      end
    end
  end

  // Issue stage: registered ROM address plus request tag; out-of-range reads address 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      rom_addr_q <= '0;
      s1_vld_q   <= 1'b0;
      s1_id_q    <= IdDisp;
      s1_oor_q   <= 1'b0;
      s1_lvl_q   <= '0;
    end else begin
      s1_vld_q <= any_gnt;
      if (any_gnt) begin
        rom_addr_q <= gnt_oor ? '0 : gnt_addr;
        s1_id_q    <= phys_gnt ? IdPhys : IdDisp;
        s1_oor_q   <= gnt_oor;
        s1_lvl_q   <= level_q;
      end
    end
  end

  // Tag follows the ROM's internal read register by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_vld_q <= 1'b0;
      s2_id_q  <= IdDisp;
      s2_oor_q <= 1'b0;
      s2_lvl_q <= '0;
    end else begin
      s2_vld_q <= s1_vld_q;
      s2_id_q  <= s1_id_q;
      s2_oor_q <= s1_oor_q;
      s2_lvl_q <= s1_lvl_q;
    end
  end

  // Response stage: route ROM word to its requester; data holds between valid pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      disp_valid_q <= 1'b0;
      phys_valid_q <= 1'b0;
      disp_data_q  <= '0;
      phys_data_q  <= '0;
    end else begin
      disp_valid_q <= s2_vld_q && (s2_id_q == IdDisp);
      phys_valid_q <= s2_vld_q && (s2_id_q == IdPhys);
      if (s2_vld_q && (s2_id_q == IdDisp)) begin
        disp_data_q <= s2_oor_q ? '0 : rom_word;
      end
      if (s2_vld_q && (s2_id_q == IdPhys)) begin
        phys_data_q <= s2_oor_q ? '0 : rom_word;
      end
    end
  end

  assign bus.disp_gnt   = disp_gnt;
  assign bus.phys_gnt   = phys_gnt;
  assign bus.disp_valid = disp_valid_q;
  assign bus.phys_valid = phys_valid_q;
  assign bus.disp_data  = disp_data_q;
  assign bus.phys_data  = phys_data_q;
  assign rom_addr       = rom_addr_q;
  assign level_cur      = level_q;

endmodule

// File: tb/tb_image_rom_arbiter.sv
// Directed bench for image_rom_arbiter with a behavioural 1-cycle-latency ROM bank.
module tb_image_rom_arbiter;

  localparam int unsigned NUM_ROMS = 4;
  localparam int unsigned LVL_W    = 3;
  localparam int unsigned ADDR_W   = 13;
  localparam int unsigned DATA_W   = 16;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       frame_start;
  logic [LVL_W-1:0]           level_req;
  logic [LVL_W-1:0]           level_cur;
  logic [ADDR_W-1:0]          rom_addr;
  logic [NUM_ROMS*DATA_W-1:0] rom_data_all = '0;
  logic [NUM_ROMS*DATA_W-1:0] rom_next;

  int checks   = 0;
  int failures = 0;

  image_rom_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  image_rom_arbiter #(
    .NUM_ROMS(NUM_ROMS),
    .LVL_W   (LVL_W),
    .ADDR_W  (ADDR_W),
    .PIXELS  (6144),
    .DATA_W  (DATA_W),
    .WAIT_MAX(15)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .level_req   (level_req),
    .level_cur   (level_cur),
    .bus         (bus),
    .rom_addr    (rom_addr),
    .rom_data_all(rom_data_all)
  );

  always #5 clk = ~clk;

  // ROM contents: rom0[5] is pure red, everything else encodes {rom index, address}.
  function automatic logic [15:0] rom_val(int k, int a);
    if (k == 0 && a == 5) return 16'hF800;
    return 16'((k << 12) | (a & 'hFFF));
  endfunction

  always_comb begin
    rom_next = '0;
    for (int k = 0; k < int'(NUM_ROMS); k++) begin
      rom_next[k*DATA_W +: DATA_W] = rom_val(k, int'(rom_addr));
    end
  end

  always @(posedge clk) rom_data_all <= rom_next;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    frame_start   = 1'b0;
    bus.disp_req  = 1'b0;
    bus.phys_req  = 1'b0;
    bus.disp_addr = '0;
    bus.phys_addr = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    level_req = '0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    checks++;
    if (level_cur !== 3'd0 || rom_addr !== 13'd0 || bus.disp_valid !== 1'b0 ||
        bus.phys_valid !== 1'b0 || bus.disp_data !== 16'h0 || bus.phys_data !== 16'h0) begin
      failures++;
      $display("FAIL reset_state: lvl=%0d addr=%0h dv=%b pv=%b dd=%h pd=%h, want all zero",
               level_cur, rom_addr, bus.disp_valid, bus.phys_valid, bus.disp_data, bus.phys_data);
    end
  endtask

  task automatic test_single_read();
    bus.disp_req  = 1'b1;
    bus.disp_addr = 13'd5;
    #1;
    checks++;
    if (bus.disp_gnt !== 1'b1 || bus.phys_gnt !== 1'b0) begin
      failures++;
      $display("FAIL single_gnt: disp_gnt=%b phys_gnt=%b, want 1 0", bus.disp_gnt, bus.phys_gnt);
    end
    step();
    bus.disp_req = 1'b0;
    checks++;
    if (rom_addr !== 13'd5) begin
      failures++;
      $display("FAIL single_rom_addr: got %0d want 5", rom_addr);
    end
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (bus.disp_valid !== (c == 3)) begin
        failures++;
        $display("FAIL single_valid_c%0d: got %b want %b", c, bus.disp_valid, (c == 3));
      end
      if (c >= 3) begin
        checks++;
        if (bus.disp_data !== 16'hF800) begin
          failures++;
          $display("FAIL single_data_c%0d: got %h want f800", c, bus.disp_data);
        end
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 12; c++) begin
      bus.disp_req  = (c < 8);
      bus.disp_addr = 13'(c < 8 ? c : 0);
      #1;
      if (c < 8) begin
        checks++;
        if (bus.disp_gnt !== 1'b1) begin
          failures++;
          $display("FAIL b2b_gnt_%0d: got %b want 1", c, bus.disp_gnt);
        end
      end
      checks++;
      if (bus.disp_valid !== (c >= 3 && c < 11)) begin
        failures++;
        $display("FAIL b2b_valid_%0d: got %b want %b", c, bus.disp_valid, (c >= 3 && c < 11));
      end
      if (c >= 3 && c < 11) begin
        checks++;
        if (bus.disp_data !== rom_val(0, c - 3)) begin
          failures++;
          $display("FAIL b2b_data_%0d: got %h want %h", c, bus.disp_data, rom_val(0, c - 3));
        end
      end
      step();
    end
  endtask

  task automatic test_starvation();
    int phys_count = 0;
    bus.disp_req  = 1'b1;
    bus.phys_req  = 1'b1;
    bus.disp_addr = 13'd100;
    bus.phys_addr = 13'd200;
    for (int c = 0; c < 40; c++) begin
      #1;
      checks++;
      if (bus.phys_gnt !== (c == 15 || c == 31) || bus.disp_gnt !== !(c == 15 || c == 31)) begin
        failures++;
        $display("FAIL starve_cycle_%0d: phys_gnt=%b disp_gnt=%b, want %b %b", c + 1,
                 bus.phys_gnt, bus.disp_gnt, (c == 15 || c == 31), !(c == 15 || c == 31));
      end
      if (bus.phys_gnt === 1'b1) phys_count++;
      step();
    end
    checks++;
    if (phys_count != 2) begin
      failures++;
      $display("FAIL starve_count: got %0d phys grants want 2", phys_count);
    end
    idle_inputs();
    for (int c = 0; c < 4; c++) step();
  endtask

  task automatic test_level_switch();
    level_req = 3'd2;
    for (int c = 0; c < 6; c++) begin
      bus.disp_req  = (c < 3);
      bus.disp_addr = 13'(10 + (c < 3 ? c : 0));
      frame_start   = (c == 1);
      #1;
      checks++;
      if (level_cur !== (c >= 2 ? 3'd2 : 3'd0)) begin
        failures++;
        $display("FAIL level_cur_%0d: got %0d want %0d", c, level_cur, (c >= 2 ? 2 : 0));
      end
      if (c >= 3) begin
        checks++;
        if (bus.disp_valid !== 1'b1 || bus.disp_data !== rom_val(c == 5 ? 2 : 0, 10 + c - 3)) begin
          failures++;
          $display("FAIL level_data_%0d: valid=%b data=%h want 1 %h", c, bus.disp_valid,
                   bus.disp_data, rom_val(c == 5 ? 2 : 0, 10 + c - 3));
        end
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_out_of_range();
    bus.phys_req  = 1'b1;
    bus.phys_addr = 13'd6144;
    #1;
    checks++;
    if (bus.phys_gnt !== 1'b1) begin
      failures++;
      $display("FAIL oor_gnt: got %b want 1", bus.phys_gnt);
    end
    step();
    bus.phys_req = 1'b0;
    checks++;
    if (rom_addr !== 13'd0) begin
      failures++;
      $display("FAIL oor_rom_addr: got %0d want 0", rom_addr);
    end
    step();
    step();
    checks++;
    if (bus.phys_valid !== 1'b1 || bus.phys_data !== 16'h0000) begin
      failures++;
      $display("FAIL oor_resp: valid=%b data=%h want 1 0000", bus.phys_valid, bus.phys_data);
    end
    level_req   = 3'd5;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    checks++;
    if (level_cur !== 3'd2) begin
      failures++;
      $display("FAIL level_invalid: got %0d want 2", level_cur);
    end
    level_req   = 3'd3;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    checks++;
    if (level_cur !== 3'd3) begin
      failures++;
      $display("FAIL level_valid: got %0d want 3", level_cur);
    end
  endtask

  task automatic test_reset_midflight();
    bus.disp_req  = 1'b1;
    bus.disp_addr = 13'd7;
    step();
    bus.disp_req = 1'b0;
    reset        = 1'b1;
    frame_start  = 1'b1;
    level_req    = 3'd1;
    step();
    reset       = 1'b0;
    frame_start = 1'b0;
    checks++;
    if (level_cur !== 3'd0 || rom_addr !== 13'd0 || bus.disp_valid !== 1'b0 ||
        bus.phys_valid !== 1'b0 || bus.disp_data !== 16'h0 || bus.phys_data !== 16'h0) begin
      failures++;
      $display("FAIL midreset_state: lvl=%0d addr=%0h dv=%b pv=%b dd=%h pd=%h, want all zero",
               level_cur, rom_addr, bus.disp_valid, bus.phys_valid, bus.disp_data, bus.phys_data);
    end
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (bus.disp_valid !== 1'b0) begin
        failures++;
        $display("FAIL midreset_no_valid_%0d: got %b want 0", c, bus.disp_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_starvation();
    test_level_switch();
    test_out_of_range();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
